// File: rtl/regbus_arbiter_pkg.sv
// Shared types and helpers for the register-bus arbiter and its round-robin picker.
package regbus_arbiter_pkg;

  // Transaction sequencer states.
  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StStrobe = 2'd1,
    StWait   = 2'd2,
    StDone   = 2'd3
  } arb_state_e;

  // Width of a requester index; at least one bit even for a single requester.
  function automatic int unsigned idx_width(int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Width of the read-latency counter: clog2(RD_LAT+1), at least one bit.
  function automatic int unsigned cnt_width(int unsigned lat);
    return (lat > 0) ? $clog2(lat + 1) : 1;
  endfunction

endpackage

// File: rtl/regbus_arbiter_rr_picker.sv
// Combinational round-robin picker: returns the first asserted request found when
// searching upward from ptr with wrap-around. Shared with other bus masters.
module regbus_arbiter_rr_picker
  import regbus_arbiter_pkg::*;
#(
  parameter int unsigned N = 2,
  localparam int unsigned IdxW = idx_width(N)
) (
  input  logic [N-1:0]    req,
  input  logic [IdxW-1:0] ptr,
  output logic [IdxW-1:0] grant,
  output logic            valid
);

  logic [IdxW-1:0] cand;

  // Walk offsets from farthest to nearest so the nearest asserted request wins.
  always_comb begin
    grant = '0;
    valid = 1'b0;
    cand  = '0;
    for (int off = int'(N) - 1; off >= 0; off--) begin
      cand = IdxW'((32'(ptr) + 32'(off)) % N);
      if (req[cand]) begin
        grant = cand;
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/regbus_arbiter.sv
// regbus_arbiter: shares the single register bus in front of the address decoder
// between N requesters. One transaction at a time: grant, one-cycle strobe, optional
// read-latency wait, then a one-cycle ack to the granted requester.
// Build option: define REGBUS_ARB_FIXED_PRIO_EN to freeze the round-robin pointer at 0
// (requester 0 highest priority). Latency and handshake are the same in both builds.
module regbus_arbiter
  import regbus_arbiter_pkg::*;
#(
  parameter int unsigned N      = 2,
  parameter int unsigned A_BITS = 16,
  parameter int unsigned D      = 8,
  parameter int unsigned RD_LAT = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [N-1:0]          req,
  input  logic [N-1:0]          we,
  input  logic [N*A_BITS-1:0]   addr,
  input  logic [N*D-1:0]        wdata,
  output logic [N-1:0]          ack,
  output logic [D-1:0]          rdata,
  output logic [A_BITS-1:0]     bus_a,
  output logic                  bus_rd,
  output logic                  bus_wr,
  output logic [D-1:0]          bus_wdata,
  input  logic [D-1:0]          bus_rdata
);

  localparam int unsigned     IdxW       = idx_width(N);
  localparam int unsigned     CntW       = cnt_width(RD_LAT);
  localparam logic [IdxW-1:0] LastIdx    = IdxW'(N - 1);
  localparam logic [CntW-1:0] CntLast    = CntW'(RD_LAT);
  // Value the decoder returns for unmapped addresses; also the rdata reset value.
  localparam logic [D-1:0]    RdataReset = {D{1'b1}};

  arb_state_e        state_q, state_d;
  logic [IdxW-1:0]   grant_q, grant_d;
  logic [IdxW-1:0]   ptr_q, ptr_d, ptr_next;
  logic [IdxW-1:0]   pick_idx;
  logic              pick_valid;
  logic              we_q, we_d;
  logic [A_BITS-1:0] bus_a_q, bus_a_d;
  logic [D-1:0]      bus_wdata_q, bus_wdata_d;
  logic [D-1:0]      rdata_q, rdata_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  int unsigned       sel;

  regbus_arbiter_rr_picker #(
    .N (N)
  ) u_picker (
    .req   (req),
    .ptr   (ptr_q),
    .grant (pick_idx),
    .valid (pick_valid)
  );

`ifdef REGBUS_ARB_FIXED_PRIO_EN
  assign ptr_next = '0;
`else
  assign ptr_next = (grant_q == LastIdx) ? '0 : grant_q + 1'b1;
`endif

  // State register; reset cuts any transaction in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (pick_valid) state_d = StStrobe;
      end
      StStrobe: begin
        if (we_q || RD_LAT == 0) state_d = StDone;
        else                     state_d = StWait;
      end
      StWait: begin
        if (cnt_q == CntLast) state_d = StDone;
      end
      StDone: begin
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Grant capture, latency counter, read-data capture and pointer advance.
  always_comb begin
    grant_d     = grant_q;
    we_d        = we_q;
    bus_a_d     = bus_a_q;
    bus_wdata_d = bus_wdata_q;
    rdata_d     = rdata_q;
    cnt_d       = cnt_q;
    ptr_d       = ptr_q;
    sel         = 32'(pick_idx);
    unique case (state_q)
      StIdle: begin
        // Request fields are sampled only here; later changes are ignored.
        if (pick_valid) begin
          grant_d     = pick_idx;
          we_d        = we[pick_idx];
          bus_a_d     = addr[sel*A_BITS +: A_BITS];
          bus_wdata_d = wdata[sel*D +: D];
        end
      end
      StStrobe: begin
        if (!we_q) begin
          if (RD_LAT == 0) rdata_d = bus_rdata;
          else             cnt_d   = CntW'(1);
        end
      end
      StWait: begin
        if (cnt_q == CntLast) rdata_d = bus_rdata;
        else                  cnt_d   = cnt_q + 1'b1;
      end
      StDone: begin
        ptr_d = ptr_next;
      end
      default: ;
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      grant_q     <= '0;
      we_q        <= 1'b0;
      bus_a_q     <= '0;
      bus_wdata_q <= '0;
      rdata_q     <= RdataReset;
      cnt_q       <= '0;
      ptr_q       <= '0;
    end else begin
      grant_q     <= grant_d;
      we_q        <= we_d;
      bus_a_q     <= bus_a_d;
      bus_wdata_q <= bus_wdata_d;
      rdata_q     <= rdata_d;
      cnt_q       <= cnt_d;
      ptr_q       <= ptr_d;
    end
  end

  // Moore outputs: strobe in StStrobe, one-hot ack in StDone.
  always_comb begin
    ack    = '0;
    bus_rd = 1'b0;
    bus_wr = 1'b0;
    unique case (state_q)
      StStrobe: begin
        bus_rd = ~we_q;
        bus_wr = we_q;
      end
      StDone: begin
        ack[grant_q] = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus_a     = bus_a_q;
  assign bus_wdata = bus_wdata_q;
  assign rdata     = rdata_q;

endmodule

// File: tb/tb_regbus_arbiter.sv
// Bench for regbus_arbiter: directed scenarios followed by random requester traffic,
// all checked against a transaction-timeline reference model and a behavioural decoder.
module tb_regbus_arbiter;

  localparam int unsigned N      = 3;
  localparam int unsigned A_BITS = 16;
  localparam int unsigned D      = 8;
  localparam int unsigned RD_LAT = 1;

  logic              clk   = 1'b0;
  logic              reset = 1'b1;
  logic [N-1:0]      req   = '0;
  logic [N-1:0]      we    = '0;
  logic [N*A_BITS-1:0] addr = '0;
  logic [N*D-1:0]    wdata = '0;
  logic [N-1:0]      ack;
  logic [D-1:0]      rdata;
  logic [A_BITS-1:0] bus_a;
  logic              bus_rd;
  logic              bus_wr;
  logic [D-1:0]      bus_wdata;
  logic [D-1:0]      bus_rdata;

  regbus_arbiter #(
    .N      (N),
    .A_BITS (A_BITS),
    .D      (D),
    .RD_LAT (RD_LAT)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .we        (we),
    .addr      (addr),
    .wdata     (wdata),
    .ack       (ack),
    .rdata     (rdata),
    .bus_a     (bus_a),
    .bus_rd    (bus_rd),
    .bus_wr    (bus_wr),
    .bus_wdata (bus_wdata),
    .bus_rdata (bus_rdata)
  );

  always #5 clk = ~clk;

  // Decoder stand-in: 16 registers at 0xDF00..0xDF0F, 0xFF elsewhere, one-cycle read latency.
  function automatic logic is_mapped(input logic [15:0] a);
    return a[15:4] == 12'hDF0;
  endfunction

  function automatic logic [7:0] init_val(input int i);
    return 8'(16 + 17 * i);
  endfunction

  logic [7:0] dev_mem [16];

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) dev_mem[i] <= init_val(i);
      bus_rdata <= '0;
    end else begin
      if (bus_wr && is_mapped(bus_a)) dev_mem[bus_a[3:0]] <= bus_wdata;
      if (bus_rd) bus_rdata <= is_mapped(bus_a) ? dev_mem[bus_a[3:0]] : 8'hFF;
    end
  end

  int n_checks = 0;
  int n_fail   = 0;
  int n_edge   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: a transaction occupies the bus for 3+lat edges from the edge that
  // grants it; strobe follows the grant edge, ack arrives lat+1 edges after it.
  int          m_busy, m_k, m_lat, m_grant, m_ptr;
  logic        m_we;
  logic [15:0] m_addr;
  logic [7:0]  m_wd;
  logic [7:0]  m_mem [16];
  logic [N-1:0] e_ack;
  logic        e_rd, e_wr;
  logic [15:0] e_bus_a;
  logic [7:0]  e_bus_wdata, e_rdata;

  task automatic model_reset();
    m_busy = 0; m_k = 0; m_lat = 0; m_ptr = 0; m_grant = 0; m_we = 1'b0;
    e_ack = '0; e_rd = 1'b0; e_wr = 1'b0;
    e_bus_a = '0; e_bus_wdata = '0; e_rdata = 8'hFF;
    for (int i = 0; i < 16; i++) m_mem[i] = init_val(i);
  endtask

  // Advance the model across the next rising edge, using the inputs presented now.
  task automatic model_edge();
    bit found;
    if (reset) begin
      model_reset();
      return;
    end
    e_ack = '0; e_rd = 1'b0; e_wr = 1'b0;
    if (m_busy != 0) begin
      m_k++;
      if (m_k == 1 + m_lat) begin
        e_ack[m_grant] = 1'b1;
        if (m_we) begin
          if (is_mapped(m_addr)) m_mem[m_addr[3:0]] = m_wd;
        end else begin
          e_rdata = is_mapped(m_addr) ? m_mem[m_addr[3:0]] : 8'hFF;
        end
      end else if (m_k == 2 + m_lat) begin
        m_busy = 0;
`ifndef REGBUS_ARB_FIXED_PRIO_EN
        m_ptr = (m_grant + 1) % N;
`endif
      end
    end else if (req != '0) begin
      found = 1'b0;
      for (int o = 0; o < N; o++) begin
        if (!found && req[(m_ptr + o) % N]) begin
          m_grant = (m_ptr + o) % N;
          found = 1'b1;
        end
      end
      m_busy = 1; m_k = 0;
      m_we   = we[m_grant];
      m_addr = addr[m_grant*A_BITS +: A_BITS];
      m_wd   = wdata[m_grant*D +: D];
      m_lat  = m_we ? 0 : RD_LAT;
      e_bus_a = m_addr; e_bus_wdata = m_wd;
      e_rd = ~m_we; e_wr = m_we;
    end
  endtask

  // Requester agents.
  int          r_start [N];
  bit          chk_lat   = 1'b0;
  bit          auto_mode = 1'b0;
  int          rearm_left = 0;
  int          ack_log [$];
  int          strobe_cnt = 0;
  logic [15:0] strobe_a = '0;
  logic [7:0]  strobe_wd = '0;

  task automatic raise(input int i, input logic w, input logic [15:0] a, input logic [7:0] d);
    req[i] = 1'b1; we[i] = w;
    addr[i*A_BITS +: A_BITS] = a;
    wdata[i*D +: D] = d;
    r_start[i] = n_edge;
  endtask

  task automatic rand_fields(input int i);
    we[i] = 1'($urandom_range(0, 1));
    addr[i*A_BITS +: A_BITS] = ($urandom_range(0, 3) != 0) ? {12'hDF0, 4'($urandom)}
                                                           : 16'($urandom);
    wdata[i*D +: D] = 8'($urandom);
  endtask

  // One clock: model step, edge, compare all outputs, then let requesters react.
  task automatic cycle();
    model_edge();
    @(posedge clk);
    #1;
    n_edge++;
    check("ack", 32'(ack), 32'(e_ack));
    check("bus_rd", 32'(bus_rd), 32'(e_rd));
    check("bus_wr", 32'(bus_wr), 32'(e_wr));
    check("bus_a", 32'(bus_a), 32'(e_bus_a));
    check("bus_wdata", 32'(bus_wdata), 32'(e_bus_wdata));
    check("rdata", 32'(rdata), 32'(e_rdata));
    if (bus_rd || bus_wr) begin
      strobe_cnt++; strobe_a = bus_a; strobe_wd = bus_wdata;
    end
    for (int i = 0; i < N; i++) begin
      if (e_ack[i]) begin
        ack_log.push_back(i);
        // Requester registers ack on the next edge: count edges from req to that edge.
        if (chk_lat) check("latency", 32'(n_edge - r_start[i] + 1), 32'(3 + m_lat));
        if (rearm_left > 0) begin
          rearm_left--;
          r_start[i] = n_edge;
        end else if (auto_mode && $urandom_range(0, 2) == 0) begin
          rand_fields(i);
          r_start[i] = n_edge;
        end else begin
          req[i] = 1'b0;
        end
      end else if (auto_mode) begin
        if (!req[i] && $urandom_range(0, 4) == 0) begin
          req[i] = 1'b1; rand_fields(i); r_start[i] = n_edge;
        end else if (req[i] && $urandom_range(0, 5) == 0) begin
          rand_fields(i);
        end
      end
    end
  endtask

  task automatic run_until_idle(input int budget);
    int n;
    n = 0;
    while ((req != '0 || m_busy != 0) && n < budget) begin
      cycle();
      n++;
    end
    check("idle_timeout", 32'(n >= budget), 32'(0));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int exp_g;
    model_reset();
    repeat (2) cycle();
    check("rst_ack", 32'(ack), 32'(0));
    check("rst_bus_rd", 32'(bus_rd), 32'(0));
    check("rst_bus_wr", 32'(bus_wr), 32'(0));
    check("rst_bus_a", 32'(bus_a), 32'(0));
    check("rst_bus_wdata", 32'(bus_wdata), 32'(0));
    check("rst_rdata", 32'(rdata), 32'hFF);
    reset = 1'b0;
    cycle();

    // Single write.
    chk_lat = 1'b1; strobe_cnt = 0;
    raise(0, 1'b1, 16'hDF02, 8'h5A);
    run_until_idle(20);
    check("t1_strobes", 32'(strobe_cnt), 32'(1));
    check("t1_bus_a", 32'(strobe_a), 32'hDF02);
    check("t1_bus_wdata", 32'(strobe_wd), 32'h5A);

    // Read with one cycle of decoder latency.
    strobe_cnt = 0;
    raise(1, 1'b0, 16'hDF00, 8'h00);
    run_until_idle(20);
    check("t2_strobes", 32'(strobe_cnt), 32'(1));
    check("t2_bus_a", 32'(strobe_a), 32'hDF00);
    check("t2_rdata", 32'(rdata), 32'h10);

    // Contention: both requesters keep requesting for four grants.
    chk_lat = 1'b0; ack_log.delete(); rearm_left = 3;
    raise(0, 1'b0, 16'hDF01, 8'h00);
    raise(1, 1'b1, 16'hDF03, 8'hC3);
    run_until_idle(200);
    check("t3_acks", 32'(ack_log.size()), 32'(5));
    for (int k = 0; k < 4 && k < ack_log.size(); k++) begin
`ifdef REGBUS_ARB_FIXED_PRIO_EN
      exp_g = 0;
`else
      exp_g = k % 2;
`endif
      check($sformatf("t3_grant%0d", k), 32'(ack_log[k]), 32'(exp_g));
    end

    // Unmapped read.
    chk_lat = 1'b1;
    raise(2, 1'b0, 16'h1234, 8'h00);
    run_until_idle(20);
    check("t4_rdata", 32'(rdata), 32'hFF);

    // Fields change after grant; the granted values must stay on the bus.
    strobe_cnt = 0;
    raise(0, 1'b1, 16'hDF02, 8'h33);
    cycle();
    addr[0 +: A_BITS] = 16'hDF05;
    wdata[0 +: D] = 8'hEE;
    run_until_idle(20);
    check("t6_strobes", 32'(strobe_cnt), 32'(1));
    check("t6_bus_a", 32'(strobe_a), 32'hDF02);
    check("t6_bus_wdata", 32'(strobe_wd), 32'h33);
    raise(0, 1'b0, 16'hDF05, 8'h00);
    run_until_idle(20);
    check("t6_df05", 32'(rdata), 32'h65);
    raise(0, 1'b0, 16'hDF02, 8'h00);
    run_until_idle(20);
    check("t6_df02", 32'(rdata), 32'h33);

    // Reset during the strobe cycle.
    chk_lat = 1'b0;
    raise(1, 1'b0, 16'hDF00, 8'h00);
    n = 0;
    while (!e_rd && n < 10) begin
      cycle();
      n++;
    end
    check("t5_strobe_seen", 32'(bus_rd), 32'(1));
    reset = 1'b1;
    model_reset();
    req = '0;
    #1;
    check("t5_bus_rd", 32'(bus_rd), 32'(0));
    check("t5_bus_wr", 32'(bus_wr), 32'(0));
    check("t5_ack", 32'(ack), 32'(0));
    check("t5_rdata", 32'(rdata), 32'hFF);
    repeat (2) cycle();
    reset = 1'b0;
    cycle();
    ack_log.delete();
    raise(0, 1'b0, 16'hDF04, 8'h00);
    raise(1, 1'b0, 16'hDF06, 8'h00);
    run_until_idle(40);
    check("t5_acks", 32'(ack_log.size()), 32'(2));
    if (ack_log.size() > 0) check("t5_first_grant", 32'(ack_log[0]), 32'(0));

    // Random traffic with one reset pulse in the middle.
    auto_mode = 1'b1;
    for (int c = 0; c < 800; c++) begin
      if (c == 400) begin
        reset = 1'b1;
        model_reset();
        req = '0;
        repeat (2) cycle();
        reset = 1'b0;
      end
      cycle();
    end
    auto_mode = 1'b0;
    run_until_idle(200);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
